// File: rtl/sprite_mover.sv
// Bouncing 4x4 block position generator: issues one plotter load per step,
// waits for the plotter's done pulse, then moves the block one pixel diagonally.
module sprite_mover #(
  parameter int TICKS_PER_STEP = 833333,
  parameter int TICK_W         = 20,
  parameter int X_MAX          = 156,
  parameter int Y_MAX          = 116,
  parameter int X_INIT         = 0,
  parameter int Y_INIT         = 0,
  parameter int WAIT_TIMEOUT   = 4096
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iEnable,
  input  logic [2:0] iColour,
  input  logic       iDone,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oLoadX,
  output logic       oBusy,
  output logic       oDirX,
  output logic       oDirY,
  output logic [7:0] oSteps,
  output logic       oError
);

  // state     | meaning
  // IDLE      | parked, waiting for iEnable
  // ISSUE     | one-cycle load strobe to the plotter
  // WAIT_DONE | waiting for the plotter's done pulse (watchdog running)
  // STEP      | move the block one pixel, bounce at the edges
  // WAIT_TICK | step-rate delay
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    STEP      = 3'd3,
    WAIT_TICK = 3'd4
  } state_t;

  localparam int WD_W = $clog2(WAIT_TIMEOUT);

  localparam logic [7:0]        X_LIM     = 8'(X_MAX);
  localparam logic [6:0]        Y_LIM     = 7'(Y_MAX);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WAIT_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [WD_W-1:0]   wdog, wdog_nxt;
  logic              wd_fire;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= IDLE;
      tick  <= '0;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
      wdog  <= wdog_nxt;
    end
  end

  // Counters default to zero so they clear on any exit from their state.
  always_comb begin
    state_nxt = IDLE;
    tick_nxt  = '0;
    wdog_nxt  = '0;
    wd_fire   = 1'b0;
    case (state)
      IDLE:      state_nxt = iEnable ? ISSUE : IDLE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (iDone) begin
          state_nxt = STEP;
        end else if (wdog == WD_LAST) begin
          wd_fire   = 1'b1;
          state_nxt = STEP;
        end else begin
          state_nxt = WAIT_DONE;
          wdog_nxt  = wdog + WD_W'(1);
        end
      end
      STEP:      state_nxt = WAIT_TICK;
      WAIT_TICK: begin
        if (tick == TICK_LAST) begin
          state_nxt = iEnable ? ISSUE : IDLE;
        end else begin
          state_nxt = WAIT_TICK;
          tick_nxt  = tick + TICK_W'(1);
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  assign oLoadX = (state == ISSUE);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oX      <= 8'(X_INIT);
      oY      <= 7'(Y_INIT);
      oColour <= 3'd0;
      oBusy   <= 1'b0;
      oDirX   <= 1'b1;
      oDirY   <= 1'b1;
      oSteps  <= 8'd0;
      oError  <= 1'b0;
    end else begin
      oBusy <= (state_nxt != IDLE);
      if (state_nxt == ISSUE) oColour <= iColour;
      if (wd_fire) oError <= 1'b1;
      if (state == STEP) begin
        oSteps <= oSteps + 8'd1;
        // Bounce reflects off the wall: the edge pixel is visited once.
        if (oDirX) begin
          if (oX >= X_LIM) begin
            oDirX <= 1'b0;
            oX    <= X_LIM - 8'd1;
          end else begin
            oX <= oX + 8'd1;
          end
        end else if (oX == 8'd0) begin
          oDirX <= 1'b1;
          oX    <= 8'd1;
        end else begin
          oX <= oX - 8'd1;
        end
        if (oDirY) begin
          if (oY >= Y_LIM) begin
            oDirY <= 1'b0;
            oY    <= Y_LIM - 7'd1;
          end else begin
            oY <= oY + 7'd1;
          end
        end else if (oY == 7'd0) begin
          oDirY <= 1'b1;
          oY    <= 7'd1;
        end else begin
          oY <= oY - 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: three instances share stimulus so the
// normal, right/bottom-start and small-canvas bounce cases run in lockstep.
module tb_sprite_mover;

  logic       clk = 1'b0;
  logic       rst, en, done;
  logic [2:0] col;

  logic [7:0] x_a, x_b, x_c, steps_a, steps_b, steps_c;
  logic [6:0] y_a, y_b, y_c;
  logic [2:0] col_a, col_b, col_c;
  logic       load_a, load_b, load_c, busy_a, busy_b, busy_c;
  logic       dx_a, dx_b, dx_c, dy_a, dy_b, dy_c, err_a, err_b, err_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sprite_mover #(.TICKS_PER_STEP(4), .TICK_W(4), .WAIT_TIMEOUT(64)) dut_a (
    .iClock(clk), .iReset(rst), .iEnable(en), .iColour(col), .iDone(done),
    .oX(x_a), .oY(y_a), .oColour(col_a), .oLoadX(load_a), .oBusy(busy_a),
    .oDirX(dx_a), .oDirY(dy_a), .oSteps(steps_a), .oError(err_a));

  sprite_mover #(.TICKS_PER_STEP(4), .TICK_W(4), .WAIT_TIMEOUT(64),
                 .X_INIT(156), .Y_INIT(116)) dut_b (
    .iClock(clk), .iReset(rst), .iEnable(en), .iColour(col), .iDone(done),
    .oX(x_b), .oY(y_b), .oColour(col_b), .oLoadX(load_b), .oBusy(busy_b),
    .oDirX(dx_b), .oDirY(dy_b), .oSteps(steps_b), .oError(err_b));

  sprite_mover #(.TICKS_PER_STEP(4), .TICK_W(4), .WAIT_TIMEOUT(64),
                 .X_MAX(2), .Y_MAX(2)) dut_c (
    .iClock(clk), .iReset(rst), .iEnable(en), .iColour(col), .iDone(done),
    .oX(x_c), .oY(y_c), .oColour(col_c), .oLoadX(load_c), .oBusy(busy_c),
    .oDirX(dx_c), .oDirY(dy_c), .oSteps(steps_c), .oError(err_c));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // From an ISSUE cycle: d cycles in WAIT_DONE, done pulse, STEP, then one
  // cycle so the new position is visible.
  task automatic run_step(input int d, input string tag);
    cyc();
    n_checks++;
    if (load_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_load_width: oLoadX=%b required 0", tag, load_a);
    end
    for (int k = 2; k <= d; k++) cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (load_a !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    n_checks++;
    if (load_a !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_wait_issue: oLoadX=%b after %0d cycles, required 1", tag, load_a, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; done = 1'b0; col = 3'd7;
    cyc();
    cyc();
    n_checks++;
    if ({x_a, y_a, load_a, busy_a, steps_a, err_a, dx_a, dy_a} !==
        {8'd0, 7'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_a: x=%0d y=%0d ld=%b busy=%b steps=%0d err=%b dx=%b dy=%b required 0 0 0 0 0 0 1 1",
               x_a, y_a, load_a, busy_a, steps_a, err_a, dx_a, dy_a);
    end
    n_checks++;
    if ({x_b, y_b, col_b} !== {8'd156, 7'd116, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_b_init: x=%0d y=%0d col=%0d required 156 116 0", x_b, y_b, col_b);
    end
    rst = 1'b0; en = 1'b0;
    cyc();
    n_checks++;
    if (busy_a !== 1'b0 || load_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b ld=%b required 0 0", busy_a, load_a);
    end
  endtask

  task automatic test_single_step();
    int cnt;
    col = 3'd5; en = 1'b1;
    cyc();
    n_checks++;
    if ({load_a, busy_a, col_a, x_a, y_a} !== {1'b1, 1'b1, 3'd5, 8'd0, 7'd0}) begin
      n_fail++;
      $display("FAIL issue: ld=%b busy=%b col=%0d x=%0d y=%0d required 1 1 5 0 0",
               load_a, busy_a, col_a, x_a, y_a);
    end
    col = 3'd2;
    cyc();
    n_checks++;
    if (load_a !== 1'b0 || col_a !== 3'd5) begin
      n_fail++;
      $display("FAIL strobe_width: ld=%b col=%0d required 0 5", load_a, col_a);
    end
    for (int k = 2; k <= 20; k++) begin
      cyc();
      n_checks++;
      if ({x_a, y_a, load_a, busy_a} !== {8'd0, 7'd0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL hold_wait_%0d: x=%0d y=%0d ld=%b busy=%b required 0 0 0 1",
                 k, x_a, y_a, load_a, busy_a);
      end
    end
    done = 1'b1;
    cyc();
    done = 1'b0;
    n_checks++;
    if ({x_a, y_a, steps_a} !== {8'd0, 7'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL step_cycle: x=%0d y=%0d steps=%0d required 0 0 0", x_a, y_a, steps_a);
    end
    cyc();
    n_checks++;
    if ({x_a, y_a, steps_a, dx_a, dy_a} !== {8'd1, 7'd1, 8'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL after_step: x=%0d y=%0d steps=%0d dx=%b dy=%b required 1 1 1 1 1",
               x_a, y_a, steps_a, dx_a, dy_a);
    end
    cnt = 2;
    while (load_a !== 1'b1 && cnt < 20) begin
      cyc();
      cnt++;
    end
    n_checks++;
    if (cnt !== 6) begin
      n_fail++;
      $display("FAIL reissue_latency: %0d cycles after done, required 6", cnt);
    end
  endtask

  task automatic test_right_bottom_bounce();
    n_checks++;
    if ({x_b, y_b, dx_b, dy_b} !== {8'd155, 7'd115, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rb_bounce: x=%0d y=%0d dx=%b dy=%b required 155 115 0 0", x_b, y_b, dx_b, dy_b);
    end
    n_checks++;
    if ({x_c, y_c} !== {8'd1, 7'd1}) begin
      n_fail++;
      $display("FAIL small_step1: x=%0d y=%0d required 1 1", x_c, y_c);
    end
  endtask

  task automatic test_left_top_bounce();
    run_step(2, "s2");
    n_checks++;
    if ({x_c, y_c, dx_c, dy_c} !== {8'd2, 7'd2, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL small_at_max: x=%0d y=%0d dx=%b dy=%b required 2 2 1 1", x_c, y_c, dx_c, dy_c);
    end
    wait_issue("s3");
    run_step(1, "s3");
    n_checks++;
    if ({x_c, y_c, dx_c, dy_c} !== {8'd1, 7'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL small_corner_max: x=%0d y=%0d dx=%b dy=%b required 1 1 0 0", x_c, y_c, dx_c, dy_c);
    end
    wait_issue("s4");
    run_step(3, "s4");
    n_checks++;
    if ({x_c, y_c, dx_c, dy_c} !== {8'd0, 7'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL small_at_zero: x=%0d y=%0d dx=%b dy=%b required 0 0 0 0", x_c, y_c, dx_c, dy_c);
    end
    wait_issue("s5");
    run_step(1, "s5");
    n_checks++;
    if ({x_c, y_c, dx_c, dy_c} !== {8'd1, 7'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL lt_bounce: x=%0d y=%0d dx=%b dy=%b required 1 1 1 1", x_c, y_c, dx_c, dy_c);
    end
    n_checks++;
    if ({x_a, y_a, steps_a, x_b} !== {8'd5, 7'd5, 8'd5, 8'd151}) begin
      n_fail++;
      $display("FAIL five_steps: xa=%0d ya=%0d steps=%0d xb=%0d required 5 5 5 151",
               x_a, y_a, steps_a, x_b);
    end
  endtask

  task automatic test_watchdog();
    wait_issue("wd");
    for (int k = 1; k <= 64; k++) cyc();
    n_checks++;
    if (err_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_early: err=%b busy=%b required 0 1", err_a, busy_a);
    end
    cyc();
    n_checks++;
    if (err_a !== 1'b1 || steps_a !== 8'd5) begin
      n_fail++;
      $display("FAIL wd_fire: err=%b steps=%0d required 1 5", err_a, steps_a);
    end
    cyc();
    n_checks++;
    if ({steps_a, x_a} !== {8'd6, 8'd6}) begin
      n_fail++;
      $display("FAIL wd_step: steps=%0d x=%0d required 6 6", steps_a, x_a);
    end
    wait_issue("wd_next");
    n_checks++;
    if (err_a !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_sticky: err=%b required 1", err_a);
    end
  endtask

  task automatic test_disable_mid_request();
    cyc();
    en = 1'b0;
    cyc();
    cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL dis_step_busy: busy=%b required 1", busy_a);
    end
    cyc();
    n_checks++;
    if ({steps_a, x_a} !== {8'd7, 8'd7}) begin
      n_fail++;
      $display("FAIL dis_step: steps=%0d x=%0d required 7 7", steps_a, x_a);
    end
    cyc();
    cyc();
    cyc();
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL dis_tick_busy: busy=%b required 1", busy_a);
    end
    cyc();
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_idle: busy=%b required 0", busy_a);
    end
    for (int k = 0; k < 20; k++) begin
      done = (k == 5);
      cyc();
      n_checks++;
      if (load_a !== 1'b0 || busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL dis_quiet_%0d: ld=%b busy=%b required 0 0", k, load_a, busy_a);
      end
    end
    done = 1'b0;
    n_checks++;
    if (steps_a !== 8'd7 || err_a !== 1'b1) begin
      n_fail++;
      $display("FAIL dis_final: steps=%0d err=%b required 7 1", steps_a, err_a);
    end
  endtask

  task automatic test_reset_mid_request();
    en = 1'b1;
    cyc();
    n_checks++;
    if (load_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_issue: ld=%b required 1", load_a);
    end
    rst = 1'b1;
    cyc();
    n_checks++;
    if ({load_a, busy_a, err_a, steps_a, x_a, col_a, dx_a, dy_a} !==
        {1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_reset: ld=%b busy=%b err=%b steps=%0d x=%0d col=%0d dx=%b dy=%b required 0 0 0 0 0 0 1 1",
               load_a, busy_a, err_a, steps_a, x_a, col_a, dx_a, dy_a);
    end
    rst = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_right_bottom_bounce();
    test_left_top_bounce();
    test_watchdog();
    test_disable_mid_request();
    test_reset_mid_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
# sprite_mover

- Upstream stage of the 4x4 pixel-block plotter.
- Generates the block's position, bouncing it around the 160x120 VGA canvas.
- Issues one load request per step: drives plotter X/Y/colour plus a one-cycle load strobe, then waits for the plotter's done pulse before stepping.
- A programmable tick divider sets the step rate.

## Interface

Parameters:
- TICKS_PER_STEP, default 833333: cycles spent in WAIT_TICK per step (60 Hz at 50 MHz); must be ≥ 4.
- TICK_W, default 20: tick counter width; 2^TICK_W > TICKS_PER_STEP.
- X_MAX, default 156: largest legal X (160 − 4).
- Y_MAX, default 116: largest legal Y (120 − 4).
- X_INIT, default 0; Y_INIT, default 0: position after reset.
- WAIT_TIMEOUT, default 4096: cycles allowed in WAIT_DONE before the watchdog fires.

Ports:
- iClock  in  1  sole clock, rising edge.
- iReset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- iEnable  in  1  run request, level.
- iColour  in  3  block colour, sampled on entry to ISSUE.
- iDone  in  1  plotter frame-done pulse.
- oX  out  8  block X to plotter.
- oY  out  7  block Y to plotter.
- oColour  out  3  colour to plotter.
- oLoadX  out  1  load strobe to plotter.
- oBusy  out  1  high in every state except IDLE.
- oDirX  out  1  X direction: 1 = +1, 0 = −1.
- oDirY  out  1  Y direction: 1 = +1, 0 = −1.
- oSteps  out  8  completed-step count, wraps 255→0.
- oError  out  1  sticky watchdog flag.

## Operation

- States: IDLE(0), ISSUE(1), WAIT_DONE(2), STEP(3), WAIT_TICK(4). Any other encoding → IDLE next cycle.
- Reset values: state IDLE; oX=X_INIT, oY=Y_INIT, oColour=0; oLoadX=0, oBusy=0; oDirX=1, oDirY=1; oSteps=0, oError=0; tick and watchdog counters 0. Reset overrides all other activity, including mid-request.
- IDLE: iEnable=1 → ISSUE, else stay.
- ISSUE: one cycle, always → WAIT_DONE. oColour ← iColour on entry.
- WAIT_DONE: watchdog increments each cycle.
  - iDone=1 → STEP.
  - Watchdog reaches WAIT_TIMEOUT−1 with no iDone → set oError, → STEP.
  - Watchdog clears on exit.
- STEP: one cycle, → WAIT_TICK. Updates position/direction and increments oSteps (mod 256). X update:
  - dirX=1 and oX<X_MAX → oX+1.
  - dirX=1 and oX==X_MAX → oDirX←0, oX←X_MAX−1.
  - dirX=0 and oX>0 → oX−1.
  - dirX=0 and oX==0 → oDirX←1, oX←1.
  - Y follows the same rules with Y_MAX and oDirY. A corner hit flips both directions in the same cycle.
- WAIT_TICK: tick counter increments from 0. At tick==TICKS_PER_STEP−1, the counter clears and:
  - iEnable=1 → ISSUE.
  - iEnable=0 → IDLE.
- Aborting: iEnable is ignored outside IDLE and the WAIT_TICK exit. An in-flight request always completes through STEP.
- iDone outside WAIT_DONE is ignored.
- Arithmetic: unsigned, native port widths. oX/oY never leave [0, X_MAX] / [0, Y_MAX].

## Timing

- oLoadX is a decode of the registered state, high exactly during the single ISSUE cycle.
- Enable latency: iEnable sampled high in IDLE at edge N → oLoadX high in cycle N+1.
- oX/oY/oColour are stable from the ISSUE cycle through the end of WAIT_DONE. The plotter samples X/Y one cycle after the strobe; this holds the values for it.
- New position is visible the cycle after STEP.
- Step period = 1 (ISSUE) + D (cycles in WAIT_DONE) + 1 (STEP) + TICKS_PER_STEP.
- Next oLoadX occurs ≥ TICKS_PER_STEP+1 cycles after iDone. This exceeds the plotter's 2-cycle return to its load state.
- oBusy is registered with the state and low only in IDLE.

## Test plan

- Reset: assert iReset 2 cycles with iEnable=1 → oX=0, oY=0, oLoadX=0, oBusy=0, oSteps=0, oError=0, oDirX=oDirY=1.
- Single step: TICKS_PER_STEP=4; enable; pulse iDone 20 cycles after oLoadX. Required:
  - oLoadX high exactly 1 cycle.
  - oX/oY=0/0 held until iDone; then 1/1.
  - oSteps=1.
  - Second oLoadX exactly 6 cycles after the iDone cycle (STEP + 4 tick cycles + ISSUE).
- Right/bottom bounce: X_INIT=156, Y_INIT=116, one step → oX=155, oY=115, oDirX=0, oDirY=0.
- Left/top bounce: X_INIT=0, Y_INIT=0, directions forced to 0 via a prior bounce sequence → next step gives oX=1/oY=1, directions back to 1.
- Watchdog: WAIT_TIMEOUT=64, never pulse iDone → STEP after 64 cycles in WAIT_DONE, oError=1 and stays high until iReset.
- Disable mid-request: drop iEnable during WAIT_DONE, then pulse iDone. Required:
  - STEP occurs and oSteps increments.
  - State reaches IDLE after the tick wait; oBusy=0.
  - No further oLoadX.
